// File: rtl/id_pkg.sv
// Shared decode constants and the control bundle for the ID stage.
//   - Opcode / funct3 constants for RV32I/RV32E base instructions.
//   - Branch codes, EX operation classes, operand-source and WB-select codes.
//   - ctrl_t: the packed control bundle produced by id_ctrl_dec.
package id_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] FCT3_BEQ  = 3'b000;
  localparam logic [2:0] FCT3_BNE  = 3'b001;
  localparam logic [2:0] FCT3_BLT  = 3'b100;
  localparam logic [2:0] FCT3_BGE  = 3'b101;
  localparam logic [2:0] FCT3_BLTU = 3'b110;
  localparam logic [2:0] FCT3_BGEU = 3'b111;
  localparam logic [2:0] FCT3_SR   = 3'b101;

  localparam logic [2:0] MEMB_NONE = 3'b000;
  localparam logic [2:0] MEMB_BEQ  = 3'b001;
  localparam logic [2:0] MEMB_BNE  = 3'b010;
  localparam logic [2:0] MEMB_BLT  = 3'b011;
  localparam logic [2:0] MEMB_BGE  = 3'b100;
  localparam logic [2:0] MEMB_JALR = 3'b101;
  localparam logic [2:0] MEMB_JAL  = 3'b111;

  localparam logic [2:0] ALU_CO_NORMAL  = 3'b000;
  localparam logic [2:0] ALU_CO_COMPARE = 3'b001;
  localparam logic [2:0] ALU_CO_NOUSE   = 3'b010;
  localparam logic [2:0] ALU_CO_JUMP    = 3'b011;
  localparam logic [2:0] ALU_CO_LOAD    = 3'b100;
  localparam logic [2:0] ALU_CO_STORE   = 3'b101;

  localparam logic [2:0] ASRC_NONE    = 3'b000;
  localparam logic [2:0] ASRC_RS1_IMM = 3'b010;
  localparam logic [2:0] ASRC_RS1_RS2 = 3'b011;
  localparam logic [2:0] ASRC_PC_IMM  = 3'b100;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_MEM  = 2'b01;
  localparam logic [1:0] WB_SEL_PCP4 = 2'b10;

  localparam logic [1:0] MEMRW_NONE  = 2'b00;
  localparam logic [1:0] MEMRW_WRITE = 2'b01;
  localparam logic [1:0] MEMRW_READ  = 2'b10;

  typedef struct packed {
    logic       regwrite;
    logic [1:0] memtoreg;
    logic [1:0] memrw;
    logic [2:0] branch;
    logic [2:0] alu_ctrl;
    logic [2:0] alu_src;
    logic [3:0] alu_fn;
  } ctrl_t;

  // Branch code from funct3; 010/011 have no branch meaning.
  function automatic logic [2:0] branch_code(input logic [2:0] f3);
    case (f3)
      FCT3_BEQ:             return MEMB_BEQ;
      FCT3_BNE:             return MEMB_BNE;
      FCT3_BLT, FCT3_BLTU:  return MEMB_BLT;
      FCT3_BGE, FCT3_BGEU:  return MEMB_BGE;
      default:              return MEMB_NONE;
    endcase
  endfunction

endpackage

// File: rtl/id_ctrl_dec.sv
// Combinational instruction decoder.
//   inst      : 32-bit instruction word
//   ctrl      : control bundle (zero for bubbles / undecodable words)
//   imm       : immediate, sign-extended to XLEN
//   uses_rs1/2: instruction reads rs1 / rs2 (hazard detection)
//   illegal   : undecodable word; only driven with ID_ILLEGAL_CHK_EN defined,
//               otherwise tied 0 and such words decode as bubbles.
module id_ctrl_dec
  import id_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic [31:0]     inst,
  output ctrl_t           ctrl,
  output logic [XLEN-1:0] imm,
  output logic            uses_rs1,
  output logic            uses_rs2,
  output logic            illegal
);

  logic               bad;
  logic signed [31:0] imm32;
  logic [6:0]         opc;
  logic [2:0]         f3;

  assign opc = inst[6:0];
  assign f3  = inst[14:12];

  // A register field beyond the implemented register count (RV32E).
  function automatic logic reg_oob(input logic [4:0] r);
    return (REG_AW < 5) && ((r >> REG_AW) != 5'd0);
  endfunction

  always_comb begin
    ctrl     = '0;
    imm32    = '0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    bad      = 1'b0;
    case (opc)
      OPC_LUI: begin
        ctrl.regwrite = 1'b1;
        ctrl.alu_ctrl = ALU_CO_NOUSE;
        imm32         = {inst[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        ctrl.regwrite = 1'b1;
        ctrl.alu_ctrl = ALU_CO_NORMAL;
        ctrl.alu_src  = ASRC_PC_IMM;
        imm32         = {inst[31:12], 12'b0};
      end
      OPC_JAL: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = WB_SEL_PCP4;
        ctrl.branch   = MEMB_JAL;
        ctrl.alu_ctrl = ALU_CO_JUMP;
        ctrl.alu_src  = ASRC_PC_IMM;
        imm32         = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OPC_JALR: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = WB_SEL_PCP4;
        ctrl.branch   = MEMB_JALR;
        ctrl.alu_ctrl = ALU_CO_JUMP;
        ctrl.alu_src  = ASRC_RS1_IMM;
        ctrl.alu_fn   = 4'b0001;
        imm32         = {{20{inst[31]}}, inst[31:20]};
        uses_rs1      = 1'b1;
      end
      OPC_LOAD: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = WB_SEL_MEM;
        ctrl.memrw    = MEMRW_READ;
        ctrl.alu_ctrl = ALU_CO_LOAD;
        ctrl.alu_src  = ASRC_RS1_IMM;
        ctrl.alu_fn   = {1'b0, f3};
        imm32         = {{20{inst[31]}}, inst[31:20]};
        uses_rs1      = 1'b1;
      end
      OPC_OPIMM: begin
        ctrl.regwrite = 1'b1;
        ctrl.alu_ctrl = ALU_CO_NORMAL;
        ctrl.alu_src  = ASRC_RS1_IMM;
        ctrl.alu_fn   = {(f3 == FCT3_SR) ? inst[30] : 1'b0, f3};
        imm32         = {{20{inst[31]}}, inst[31:20]};
        uses_rs1      = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl.branch   = branch_code(f3);
        ctrl.alu_ctrl = ALU_CO_COMPARE;
        ctrl.alu_src  = ASRC_RS1_RS2;
        ctrl.alu_fn   = {1'b0, f3};
        imm32         = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
        bad           = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_STORE: begin
        ctrl.memrw    = MEMRW_WRITE;
        ctrl.alu_ctrl = ALU_CO_STORE;
        ctrl.alu_src  = ASRC_RS1_IMM;
        ctrl.alu_fn   = {1'b0, f3};
        imm32         = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
      end
      OPC_OP: begin
        ctrl.regwrite = 1'b1;
        ctrl.alu_ctrl = ALU_CO_NORMAL;
        ctrl.alu_src  = ASRC_RS1_RS2;
        ctrl.alu_fn   = {inst[30], f3};
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
        bad           = (inst[31:25] != 7'b0000000) && (inst[31:25] != 7'b0100000);
      end
      default: bad = 1'b1;
    endcase

    if (inst[1:0] != 2'b11) bad = 1'b1;
    if ((uses_rs1 && reg_oob(inst[19:15])) ||
        (uses_rs2 && reg_oob(inst[24:20])) ||
        (ctrl.regwrite && reg_oob(inst[11:7])))
      bad = 1'b1;

    // Undecodable words become bubbles: no side effects, no operands.
    if (bad) begin
      ctrl     = '0;
      imm32    = '0;
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
    end
  end

  // Signed source makes the size cast sign-extend for XLEN=64.
  assign imm = XLEN'(imm32);

`ifdef ID_ILLEGAL_CHK_EN
  assign illegal = bad;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: rtl/id_stage_hs.sv
// Instruction-decode stage with valid/ready handshake and a one-entry output
// register. Contains the load-use interlock, WB-to-ID bypass (also applied to
// a held entry) and flush.
//   in_*          : instruction from IF (valid/ready)
//   rf_raddr*/rdata*: register-file read port (same-cycle data)
//   wb_*          : writeback port used for bypassing
//   ex_*          : EX-stage occupant, for the load-use interlock
//   flush         : redirect; kills the held entry and the input this cycle
//   out_*         : decoded entry to EX (valid/ready)
// Optional: ID_ILLEGAL_CHK_EN enables out_illegal (tied 0 when undefined).
module id_stage_hs
  import id_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_pcp4,
  input  logic [31:0]       in_inst,
  input  logic              flush,
  output logic [REG_AW-1:0] rf_raddr1,
  output logic [REG_AW-1:0] rf_raddr2,
  input  logic [XLEN-1:0]   rf_rdata1,
  input  logic [XLEN-1:0]   rf_rdata2,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_pcp4,
  output logic [XLEN-1:0]   out_imm,
  output logic [XLEN-1:0]   out_rs1_data,
  output logic [XLEN-1:0]   out_rs2_data,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_regwrite,
  output logic [1:0]        out_memtoreg,
  output logic [1:0]        out_memrw,
  output logic [2:0]        out_branch,
  output logic [2:0]        out_alu_ctrl,
  output logic [2:0]        out_alu_src,
  output logic [3:0]        out_alu_fn,
  output logic [6:0]        out_funct7,
  output logic [31:0]       out_inst,
  output logic              out_illegal
);

  ctrl_t             dec_ctrl;
  logic [XLEN-1:0]   dec_imm;
  logic              dec_uses_rs1;
  logic              dec_uses_rs2;
  logic              dec_illegal;

  logic [REG_AW-1:0] rs1, rs2, held_rs1, held_rs2;
  logic [XLEN-1:0]   byp1, byp2;
  logic              hz, accept, drain;

  id_ctrl_dec #(.XLEN(XLEN), .REG_AW(REG_AW)) u_dec (
    .inst     (in_inst),
    .ctrl     (dec_ctrl),
    .imm      (dec_imm),
    .uses_rs1 (dec_uses_rs1),
    .uses_rs2 (dec_uses_rs2),
    .illegal  (dec_illegal)
  );

  assign rs1       = in_inst[15 +: REG_AW];
  assign rs2       = in_inst[20 +: REG_AW];
  assign rf_raddr1 = rs1;
  assign rf_raddr2 = rs2;
  assign held_rs1  = out_inst[15 +: REG_AW];
  assign held_rs2  = out_inst[20 +: REG_AW];

  assign hz = in_valid && ex_valid && ex_is_load && (ex_rd != '0) &&
              ((dec_uses_rs1 && (ex_rd == rs1)) || (dec_uses_rs2 && (ex_rd == rs2)));

  assign drain    = !out_valid || out_ready;
  assign in_ready = drain && !hz && !flush;
  assign accept   = in_valid && in_ready;

  assign byp1 = (rs1 == '0) ? '0 :
                (wb_we && (wb_rd == rs1)) ? wb_data : rf_rdata1;
  assign byp2 = (rs2 == '0) ? '0 :
                (wb_we && (wb_rd == rs2)) ? wb_data : rf_rdata2;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_pcp4     <= '0;
      out_imm      <= '0;
      out_rs1_data <= '0;
      out_rs2_data <= '0;
      out_rd       <= '0;
      out_regwrite <= 1'b0;
      out_memtoreg <= '0;
      out_memrw    <= '0;
      out_branch   <= '0;
      out_alu_ctrl <= '0;
      out_alu_src  <= '0;
      out_alu_fn   <= '0;
      out_funct7   <= '0;
      out_inst     <= '0;
      out_illegal  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_pc       <= in_pc;
      out_pcp4     <= in_pcp4;
      out_imm      <= dec_imm;
      out_rs1_data <= byp1;
      out_rs2_data <= byp2;
      // Only writing formats carry rd; bubbles and branch/store get 0.
      out_rd       <= dec_ctrl.regwrite ? in_inst[7 +: REG_AW] : '0;
      out_regwrite <= dec_ctrl.regwrite;
      out_memtoreg <= dec_ctrl.memtoreg;
      out_memrw    <= dec_ctrl.memrw;
      out_branch   <= dec_ctrl.branch;
      out_alu_ctrl <= dec_ctrl.alu_ctrl;
      out_alu_src  <= dec_ctrl.alu_src;
      out_alu_fn   <= dec_ctrl.alu_fn;
      out_funct7   <= in_inst[31:25];
      out_inst     <= in_inst;
      out_illegal  <= dec_illegal;
    end else if (drain) begin
      out_valid <= 1'b0;
    end else begin
      // Held entry: keep operands current with writebacks that land meanwhile.
      if (wb_we && (wb_rd != '0) && (wb_rd == held_rs1)) out_rs1_data <= wb_data;
      if (wb_we && (wb_rd != '0) && (wb_rd == held_rs2)) out_rs2_data <= wb_data;
    end
  end

endmodule

// File: tb/tb_id_stage_hs.sv
module tb_id_stage_hs;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [31:0] I_ADDI = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] I_ADD  = 32'h001101B3; // add  x3,x2,x1
  localparam logic [31:0] I_LUI  = 32'h123452B7; // lui  x5,0x12345

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready;
  logic [XLEN-1:0]   in_pc, in_pcp4;
  logic [31:0]       in_inst;
  logic              flush;
  logic [REG_AW-1:0] rf_raddr1, rf_raddr2;
  logic [XLEN-1:0]   rf_rdata1, rf_rdata2;
  logic              wb_we;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              ex_valid, ex_is_load;
  logic [REG_AW-1:0] ex_rd;
  logic              out_valid, out_ready;
  logic [XLEN-1:0]   out_pc, out_pcp4, out_imm, out_rs1_data, out_rs2_data;
  logic [REG_AW-1:0] out_rd;
  logic              out_regwrite;
  logic [1:0]        out_memtoreg, out_memrw;
  logic [2:0]        out_branch, out_alu_ctrl, out_alu_src;
  logic [3:0]        out_alu_fn;
  logic [6:0]        out_funct7;
  logic [31:0]       out_inst;
  logic              out_illegal;

  int checks   = 0;
  int failures = 0;

`ifdef ID_ILLEGAL_CHK_EN
  localparam logic EXP_ILL = 1'b1;
`else
  localparam logic EXP_ILL = 1'b0;
`endif

  id_stage_hs #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_pcp4(in_pcp4), .in_inst(in_inst),
    .flush(flush),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pcp4(out_pcp4), .out_imm(out_imm),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_rd(out_rd), .out_regwrite(out_regwrite),
    .out_memtoreg(out_memtoreg), .out_memrw(out_memrw),
    .out_branch(out_branch), .out_alu_ctrl(out_alu_ctrl),
    .out_alu_src(out_alu_src), .out_alu_fn(out_alu_fn),
    .out_funct7(out_funct7), .out_inst(out_inst), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    in_valid = 1'b0; flush = 1'b0; wb_we = 1'b0;
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = '0;
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1; in_inst = I_ADDI;
    in_pc = 32'h100; in_pcp4 = 32'h104; out_ready = 1'b0;
    rf_rdata1 = '0; rf_rdata2 = '0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = '0;
    step(); step();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", out_valid); end
    checks++; if (out_inst !== 32'h0) begin failures++; $display("FAIL reset_inst got=%h exp=00000000", out_inst); end
    checks++; if (out_imm !== 32'h0) begin failures++; $display("FAIL reset_imm got=%h exp=0", out_imm); end
    checks++; if (out_rd !== 5'd0 || out_regwrite !== 1'b0) begin failures++; $display("FAIL reset_rd_rw got=%0d/%0d exp=0/0", out_rd, out_regwrite); end
    checks++; if (out_illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%0h exp=0", out_illegal); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
  endtask

  task automatic test_addi();
    in_valid = 1'b1; in_inst = I_ADDI; in_pc = 32'h100; in_pcp4 = 32'h104;
    rf_rdata1 = 32'h1234; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL addi_in_ready got=%0h exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL addi_valid got=%0h exp=1", out_valid); end
    checks++; if (out_imm !== 32'd5) begin failures++; $display("FAIL addi_imm got=%h exp=5", out_imm); end
    checks++; if (out_rd !== 5'd1) begin failures++; $display("FAIL addi_rd got=%0d exp=1", out_rd); end
    checks++; if (out_alu_src !== 3'b010 || out_regwrite !== 1'b1) begin failures++; $display("FAIL addi_src_rw got=%b/%b exp=010/1", out_alu_src, out_regwrite); end
    checks++; if (out_rs1_data !== 32'h0) begin failures++; $display("FAIL addi_x0_read got=%h exp=0", out_rs1_data); end
    checks++; if (out_pc !== 32'h100 || out_pcp4 !== 32'h104) begin failures++; $display("FAIL addi_pc got=%h/%h exp=100/104", out_pc, out_pcp4); end
  endtask

  task automatic test_load_use();
    out_ready = 1'b1;
    ex_valid = 1'b1; ex_is_load = 1'b0; ex_rd = 5'd2;
    in_valid = 1'b1; in_inst = I_ADD; rf_rdata1 = 32'h11; rf_rdata2 = 32'h22;
    #1;
    checks++; if (rf_raddr1 !== 5'd2 || rf_raddr2 !== 5'd1) begin failures++; $display("FAIL raddr got=%0d/%0d exp=2/1", rf_raddr1, rf_raddr2); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL nonload_no_stall got=%0h exp=1", in_ready); end
    ex_is_load = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL loaduse_stall got=%0h exp=0", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL loaduse_bubble got=%0h exp=0", out_valid); end
    ex_valid = 1'b0; ex_is_load = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL loaduse_release got=%0h exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_rd !== 5'd3) begin failures++; $display("FAIL add_accept got=%0h/%0d exp=1/3", out_valid, out_rd); end
    checks++; if (out_rs1_data !== 32'h11 || out_rs2_data !== 32'h22) begin failures++; $display("FAIL add_ops got=%h/%h exp=11/22", out_rs1_data, out_rs2_data); end
    checks++; if (out_alu_src !== 3'b011 || out_alu_fn !== 4'b0000) begin failures++; $display("FAIL add_ctl got=%b/%b exp=011/0000", out_alu_src, out_alu_fn); end
  endtask

  task automatic test_hold_bypass();
    drive_idle();
    in_valid = 1'b1; in_inst = I_ADD; rf_rdata1 = 32'h0; rf_rdata2 = 32'h22;
    step();
    in_inst = I_ADDI; out_ready = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL hold_in_ready got=%0h exp=0", in_ready); end
    wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'hDEAD; rf_rdata1 = 32'h999;
    step();
    checks++; if (out_valid !== 1'b1 || out_rs1_data !== 32'hDEAD) begin failures++; $display("FAIL hold_refresh got=%0h/%h exp=1/0000dead", out_valid, out_rs1_data); end
    checks++; if (out_rs2_data !== 32'h22 || out_rd !== 5'd3 || out_inst !== I_ADD) begin failures++; $display("FAIL hold_stable got=%h/%0d/%h exp=22/3/%h", out_rs2_data, out_rd, out_inst, I_ADD); end
    wb_rd = 5'd5; wb_data = 32'hBEEF;
    step();
    checks++; if (out_rs1_data !== 32'hDEAD || out_rs2_data !== 32'h22) begin failures++; $display("FAIL hold_no_match got=%h/%h exp=dead/22", out_rs1_data, out_rs2_data); end
    wb_we = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hold_release got=%0h exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_inst !== I_ADDI) begin failures++; $display("FAIL after_hold got=%0h/%h exp=1/%h", out_valid, out_inst, I_ADDI); end
  endtask

  task automatic test_bypass_accept();
    drive_idle();
    in_valid = 1'b1; in_inst = I_ADD; rf_rdata1 = 32'h11; rf_rdata2 = 32'h22;
    wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'h55;
    step();
    checks++; if (out_rs1_data !== 32'h11 || out_rs2_data !== 32'h55) begin failures++; $display("FAIL bypass_rs2 got=%h/%h exp=11/55", out_rs1_data, out_rs2_data); end
    in_inst = I_ADDI; wb_rd = 5'd0; wb_data = 32'h77; rf_rdata1 = 32'h1234;
    step();
    in_valid = 1'b0; wb_we = 1'b0;
    checks++; if (out_rs1_data !== 32'h0) begin failures++; $display("FAIL bypass_x0 got=%h exp=0", out_rs1_data); end
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [17:0] ctl;   // regwrite,memtoreg,memrw,branch,alu_ctrl,alu_src,alu_fn
    logic [31:0] imm;
    logic [4:0]  rd;
  } vec_t;

  task automatic test_back_to_back_decode();
    vec_t v[10];
    logic [17:0] got;
    v[0] = '{32'h123452B7, 18'b1_00_00_000_010_000_0000, 32'h12345000, 5'd5}; // lui
    v[1] = '{32'h00001297, 18'b1_00_00_000_000_100_0000, 32'h00001000, 5'd5}; // auipc
    v[2] = '{32'h010000EF, 18'b1_10_00_111_011_100_0000, 32'h00000010, 5'd1}; // jal
    v[3] = '{32'h004100E7, 18'b1_10_00_101_011_010_0001, 32'h00000004, 5'd1}; // jalr
    v[4] = '{32'h0000A103, 18'b1_01_10_000_100_010_0010, 32'h00000000, 5'd2}; // lw
    v[5] = '{32'h4030D093, 18'b1_00_00_000_000_010_1101, 32'h00000403, 5'd1}; // srai
    v[6] = '{32'h00209463, 18'b0_00_00_010_001_011_0001, 32'h00000008, 5'd0}; // bne
    v[7] = '{32'hFE20ECE3, 18'b0_00_00_011_001_011_0110, 32'hFFFFFFF8, 5'd0}; // bltu
    v[8] = '{32'hFE20AE23, 18'b0_00_01_000_101_010_0010, 32'hFFFFFFFC, 5'd0}; // sw
    v[9] = '{32'h401101B3, 18'b1_00_00_000_000_011_1000, 32'h00000000, 5'd3}; // sub
    drive_idle();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_inst = v[i].inst;
      step();
      got = {out_regwrite, out_memtoreg, out_memrw, out_branch, out_alu_ctrl, out_alu_src, out_alu_fn};
      checks++;
      if (out_valid !== 1'b1 || got !== v[i].ctl || out_imm !== v[i].imm ||
          out_rd !== v[i].rd || out_illegal !== 1'b0 || out_funct7 !== v[i].inst[31:25]) begin
        failures++;
        $display("FAIL decode[%0d] inst=%h got v=%0h ctl=%b imm=%h rd=%0d ill=%0h exp ctl=%b imm=%h rd=%0d",
                 i, v[i].inst, out_valid, got, out_imm, out_rd, out_illegal, v[i].ctl, v[i].imm, v[i].rd);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_flush();
    drive_idle();
    in_valid = 1'b1; in_inst = I_ADDI; flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%0h exp=0", in_ready); end
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_input got=%0h exp=0", out_valid); end
    in_valid = 1'b1; in_inst = I_ADDI;
    step();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL flush_setup got=%0h exp=1", out_valid); end
    out_ready = 1'b0; flush = 1'b1; in_inst = I_LUI;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_held_ready got=%0h exp=0", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_held got=%0h exp=0", out_valid); end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_not_consumed got=%0h exp=0", out_valid); end
  endtask

  task automatic test_illegal();
    logic [31:0] ill[4];
    ill[0] = 32'h0000000B; // custom-0 opcode
    ill[1] = 32'h00000000; // inst[1:0] = 00
    ill[2] = 32'h021101B3; // OP with funct7 0000001
    ill[3] = 32'h0020A463; // BRANCH with f3 010
    drive_idle();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_inst = ill[i];
      step();
      checks++;
      if (out_valid !== 1'b1 || out_illegal !== EXP_ILL || out_regwrite !== 1'b0 ||
          out_memrw !== 2'b00 || out_rd !== 5'd0 || out_branch !== 3'b000) begin
        failures++;
        $display("FAIL illegal[%0d] inst=%h got v=%0h ill=%0h rw=%0h mem=%b rd=%0d br=%b exp v=1 ill=%0h rw=0 mem=00 rd=0 br=000",
                 i, ill[i], out_valid, out_illegal, out_regwrite, out_memrw, out_rd, out_branch, EXP_ILL);
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_use();
    test_hold_bypass();
    test_bypass_accept();
    test_back_to_back_decode();
    test_flush();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_stage_hs.md
Name: id_stage_hs

Overview:
- Parametrised successor to the current instruction-decode pipeline register; sits between IF/IR and EX.
- Decodes RV32I/RV32E base integer instructions into EX/MEM/WB control fields and generates the immediate.
- Replaces global keep/nop with a valid/ready handshake and a one-entry output register.
- Adds an internal load-use interlock, WB-to-ID bypass (including for a held entry), and flush.

Parameters:
- XLEN, 32, datapath/PC width (32 or 64); immediates sign-extended to XLEN.
- REG_AW, 5, register-address width; 5 = RV32I, 4 = RV32E.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  IF offers an instruction.
- in_ready  out  1  ID accepts this cycle.
- in_pc / in_pcp4  in  XLEN  instruction PC and PC+4.
- in_inst  in  32  instruction word.
- flush  in  1  branch/jump redirect from EX/MEM; kill the held entry and the input.
- rf_raddr1 / rf_raddr2  out  REG_AW  equal inst[15+:REG_AW] / inst[20+:REG_AW] (combinational).
- rf_rdata1 / rf_rdata2  in  XLEN  register file read data, same cycle.
- wb_we  in  1  WB write enable.
- wb_rd  in  REG_AW  WB destination.
- wb_data  in  XLEN  WB data.
- ex_valid  in  1  EX holds a valid instruction.
- ex_is_load  in  1  EX instruction is a load.
- ex_rd  in  REG_AW  EX destination.
- out_valid  out  1  decoded entry valid.
- out_ready  in  1  EX accepts.
- out_pc / out_pcp4  out  XLEN  PC and PC+4.
- out_imm  out  XLEN  immediate.
- out_rs1_data / out_rs2_data  out  XLEN  operands.
- out_rd  out  REG_AW  destination register.
- out_regwrite  out  1  register write enable.
- out_memtoreg  out  2  WB source select.
- out_memrw  out  2  memory read/write.
- out_branch  out  3  branch/jump code.
- out_alu_ctrl  out  3  EX operation class.
- out_alu_src  out  3  operand source select.
- out_alu_fn  out  4  ALU function.
- out_funct7  out  7  funct7 field.
- out_inst  out  32  instruction word.
- out_illegal  out  1  illegal instruction (feature only; tied 0 otherwise).

Behaviour:
- Reset (rst=1 at posedge): out_valid=0 and every out_* register = 0 (out_inst = 0, not a NOP encoding). in_ready is combinational and is therefore 1 after reset.
- Hazard, combinational: hz = in_valid & ex_valid & ex_is_load & ex_rd≠0 & ((uses_rs1 & ex_rd==rs1) | (uses_rs2 & ex_rd==rs2)).
  - uses_rs1: all formats except LUI, AUIPC, JAL.
  - uses_rs2: BRANCH, STORE, OP only.
- Ready: in_ready = (~out_valid | out_ready) & ~hz & ~flush.
- Accept (in_valid & in_ready): register all decoded fields next cycle; out_valid=1. Latency is 1 cycle.
- Operand bypass on accept: rsN_data = (wb_we & wb_rd≠0 & wb_rd==rsN) ? wb_data : rf_rdataN. x0 always reads 0.
- Bubble: if (~out_valid | out_ready) and the input is not accepted (in_valid=0, hz, or flush), then out_valid←0. Payload registers may hold stale values; the bench checks the payload only when out_valid=1.
- Hold (out_valid & ~out_ready & ~flush): all fields stable, except out_rsN_data, which is refreshed from the WB bypass when wb_we & wb_rd≠0 & wb_rd equals the held rsN.
- Flush takes priority over accept and hold: out_valid←0 next cycle and in_ready=0 that cycle.
- Reset takes priority over flush.
- Decode fields per opcode:

| Opcode | regwrite | memtoreg | memrw | branch | alu_ctrl | alu_src | imm | alu_fn |
|---|---|---|---|---|---|---|---|---|
| LUI | 1 | 00 | 00 | 000 | 010 | 000 | U | 0 |
| AUIPC | 1 | 00 | 00 | 000 | 000 | 100 | U | 0 |
| JAL | 1 | 10 | 00 | 111 | 011 | 100 | J | 0000 |
| JALR | 1 | 10 | 00 | 101 | 011 | 010 | I | 0001 |
| LOAD | 1 | 01 | 10 | 000 | 100 | 010 | I | {0,f3} |
| OP-IMM | 1 | 00 | 00 | 000 | 000 | 010 | I | {f3==101 ? inst[30] : 0, f3} |
| BRANCH | 0 | 00 | 00 | see below | 001 | 011 | B | {0,f3} |
| STORE | 0 | 00 | 01 | 000 | 101 | 010 | S | {0,f3} |
| OP | 1 | 00 | 00 | 000 | 000 | 011 | 0 | {inst[30],f3} |

- BRANCH codes: BEQ→001, BNE→010, BLT/BLTU→011, BGE/BGEU→100. Signedness is carried in alu_fn[2:0].
- out_rd = 0 for BRANCH and STORE.
- Any other opcode is accepted as a valid bubble with all control fields 0 and out_rd = 0.
- Immediates are sign-extended to XLEN from bit 31; the U immediate is sign-extended above bit 31 when XLEN=64.

Optional Feature:
- Macro: ID_ILLEGAL_CHK_EN.
- Defined: out_illegal=1 with regwrite=0 and memrw=0 for any of:
  - an unknown opcode;
  - inst[1:0]≠11;
  - BRANCH with f3 ∈ {010, 011};
  - OP with funct7 ∉ {0000000, 0100000};
  - a register field ≥ 2^REG_AW (RV32E).
- Undefined: out_illegal tied 0; these cases decode as bubbles.

Decomposition:
- Package id_pkg:
  - opcode constants;
  - FCT3_* constants;
  - MEMB_* codes (NONE=000, BEQ=001, BNE=010, BLT=011, BGE=100, JALR=101, JAL=111);
  - ALU_CO_* classes (NORMAL, COMPARE, NOUSE, JUMP, LOAD, STORE);
  - WB_SEL_* codes (ALU=00, MEM=01, PCP4=10);
  - a packed struct for the control bundle.
- One combinational sub-module, id_ctrl_dec: inst → control struct, imm, uses_rs1, uses_rs2, illegal. The top level owns the handshake, hazard, bypass and registers.

Test Plan:
- Reset then ADDI x1,x0,5 (0x00500093), out_ready=1 → next cycle out_valid=1, out_imm=5, out_rd=1, alu_src=010, regwrite=1.
- LW x2,0(x1) in EX (ex_is_load=1, ex_rd=2), then ADD x3,x2,x1 offered → in_ready=0 for 1 cycle, out_valid=0 (bubble); ADD is accepted the next cycle.
- out_ready=0 holding ADD x3,x2,x1 with rs1 data 0, then wb_we=1, wb_rd=2, wb_data=0xDEAD → out_rs1_data becomes 0xDEAD while the other fields stay stable.
- BLTU x1,x2,-8 → branch=011, alu_fn=0110, imm=0xFFFFFFF8, out_rd=0.
- flush asserted together with in_valid and with a held entry → the next cycle out_valid=0 and the input is not consumed.
- With ID_ILLEGAL_CHK_EN, in_inst=0x0000000B → out_illegal=1, regwrite=0. Without the macro → out_illegal=0 and the instruction is a bubble.
